regfile_dump: RTL and testbench
===============================

Name: regfile_dump

Overview:
Parametrised general-purpose register file for the multicycle MIPS datapath. It has two combinational read ports and one synchronous write port. An optional write-to-read bypass and a hardwired-zero register 0 are selectable by parameter. A valid/ready dump engine streams every register out in address order for debug and testbench checking, which replaces the file-dump approach used in simulation. A combinational debug peek port also returns any single register.

Parameters:
DATA_W, 32, register width in bits
ADDR_W, 5, address width; DEPTH = 2**ADDR_W registers
ZERO_REG, 1, 1: register 0 always reads 0 and writes to it are discarded; 0: register 0 is ordinary storage
BYPASS, 1, 1: a read of the address being written this cycle returns wdata; 0: it returns the stored (old) value

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-high reset
we  in  1  write enable
waddr  in  ADDR_W  write address
wdata  in  DATA_W  write data
raddr1  in  ADDR_W  read port 1 address
raddr2  in  ADDR_W  read port 2 address
rdata1  out  DATA_W  read port 1 data (combinational)
rdata2  out  DATA_W  read port 2 data (combinational)
dbg_addr  in  ADDR_W  peek address
dbg_data  out  DATA_W  peek data (combinational, never bypassed)
dump_start  in  1  one-cycle request to start a dump
dump_abort  in  1  cancels a dump in progress
dump_busy  out  1  dump engine is not IDLE
dump_valid  out  1  dump_addr and dump_data hold a beat
dump_ready  in  1  consumer accepts the beat
dump_addr  out  ADDR_W  index of the current beat
dump_data  out  DATA_W  registered value of the current beat
dump_done  out  1  one-cycle pulse after the last beat is accepted

Behaviour:
- Reset (async, active-high) clears all DEPTH registers to 0 and puts the FSM in IDLE. dump_busy, dump_valid, dump_done, dump_addr and dump_data are all 0 during and after reset.
- Write: on the rising edge when we=1, reg[waddr] <= wdata. When ZERO_REG=1 and waddr=0, the write is dropped.
- Read ports rdata1, rdata2 and dbg_data:
  - Return 0 for address 0 when ZERO_REG=1.
  - Otherwise, when BYPASS=1 and we=1 and raddrN==waddr, return wdata.
  - Otherwise return the stored value.
- dbg_data ignores BYPASS and always returns the stored value (still 0 for address 0 when ZERO_REG=1).
- Dump FSM has three states: IDLE, SEND, DONE.
  - IDLE: on dump_start=1, next state is SEND with dump_addr=0 and dump_data=reg[0] (sampled at that edge), dump_valid=1, dump_busy=1.
  - SEND, dump_valid && dump_ready at index i < DEPTH-1: the next cycle shows dump_addr=i+1 and dump_data=reg[i+1]. Back-to-back beats run at one per cycle.
  - SEND, stall (dump_ready=0): dump_addr and dump_data hold stable. They are not updated even if reg[i] is written during the stall.
  - SEND, beat at index DEPTH-1 accepted: go to DONE. dump_valid=0 and dump_done=1 for exactly one cycle, dump_busy stays 1.
  - DONE: go to IDLE on the next cycle; dump_busy=0 and dump_done=0.
- Sampling rule: each beat's dump_data is loaded at the edge that advances to it, using the pre-write value. A same-edge write to that index is not captured.
- Register 0 is dumped as 0 when ZERO_REG=1.
- dump_start is ignored when the FSM is not IDLE.
- dump_abort=1 in SEND or DONE: next state is IDLE with dump_valid=0 and no dump_done pulse. If dump_abort and dump_start are both 1 in IDLE, abort wins and the FSM stays IDLE.
- Reads and writes on the register ports are never blocked by the dump engine.
- A dump transfers exactly DEPTH beats; dump_addr never wraps within a dump.
- Reset asserted mid-dump ends the dump immediately, with no done pulse, and clears the array.

Test Plan:
- Reset, then write 0xDEADBEEF to r5, set raddr1=5 -> rdata1=0xDEADBEEF on the next cycle. Set raddr2=0 -> rdata2=0.
- ZERO_REG=1: write 0x1234 to r0 -> rdata1, dbg_data and the r0 dump beat all read 0. ZERO_REG=0 -> r0 reads 0x1234.
- BYPASS=1: in the same cycle drive we=1, waddr=7, wdata=0xA5A5A5A5, raddr1=7 -> rdata1=0xA5A5A5A5 in that cycle. BYPASS=0 -> the old value (0 after reset). dbg_data returns the old value in both cases.
- Load reg[i]=i*0x11, pulse dump_start, hold dump_ready=1 -> 32 consecutive beats with addr 0..31 and data i*0x11 (r0=0), then dump_done for exactly 1 cycle, then dump_busy=0.
- Stall at beat 3 for 4 cycles while writing 0xFFFF to r3 -> dump_data stays 0x33 through the stall. Re-pulse dump_start during the dump -> ignored (exactly one dump_done).
- Assert dump_abort at beat 10 -> dump_valid=0 next cycle, no dump_done. Assert rst mid-dump -> all outputs 0 asynchronously and every register reads 0.

Source files
------------

// File: rtl/regfile_dump_if.sv
// Register file bus: write port, two read ports, debug peek and the dump stream.
// Ports (signals):
//   we/waddr/wdata           write port (master -> slave)
//   raddr1/raddr2 -> rdata1/rdata2  combinational read ports
//   dbg_addr -> dbg_data     combinational peek, never bypassed
//   dump_start/dump_abort/dump_ready   dump control (master -> slave)
//   dump_busy/dump_valid/dump_addr/dump_data/dump_done   dump stream (slave -> master)
interface regfile_dump_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic [ADDR_W-1:0] raddr1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata1;
  logic [DATA_W-1:0] rdata2;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              dump_start;
  logic              dump_abort;
  logic              dump_busy;
  logic              dump_valid;
  logic              dump_ready;
  logic [ADDR_W-1:0] dump_addr;
  logic [DATA_W-1:0] dump_data;
  logic              dump_done;

  modport master (
    output we, waddr, wdata, raddr1, raddr2, dbg_addr,
    output dump_start, dump_abort, dump_ready,
    input  rdata1, rdata2, dbg_data,
    input  dump_busy, dump_valid, dump_addr, dump_data, dump_done
  );

  modport slave (
    input  we, waddr, wdata, raddr1, raddr2, dbg_addr,
    input  dump_start, dump_abort, dump_ready,
    output rdata1, rdata2, dbg_data,
    output dump_busy, dump_valid, dump_addr, dump_data, dump_done
  );
endinterface

// File: rtl/regfile_dump.sv
// General-purpose register file with a valid/ready dump engine for debug.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset (clears all registers, FSM to IDLE)
//   bus   regfile_dump_if.slave: write port, two read ports, debug peek,
//         dump control and dump stream
// Parameters: DATA_W, ADDR_W (DEPTH = 2**ADDR_W), ZERO_REG (r0 hardwired 0),
//             BYPASS (same-cycle write data forwarded to read ports).
module regfile_dump #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic           clk,
  input logic           rst,
  regfile_dump_if.slave bus
);

  localparam int unsigned       DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] dump_addr_q;
  logic [DATA_W-1:0] dump_data_q;
  logic              load;
  logic [ADDR_W-1:0] load_idx;
  logic              wr_drop;

  // Writes to r0 vanish when it is hardwired to zero.
  assign wr_drop = (ZERO_REG != 0) && (bus.waddr == '0);

  // Storage array.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (bus.we && !wr_drop) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  // Read port 1: zero register beats bypass, bypass beats stored value.
  always_comb begin
    bus.rdata1 = mem[bus.raddr1];
    if ((BYPASS != 0) && bus.we && (bus.raddr1 == bus.waddr)) begin
      bus.rdata1 = bus.wdata;
    end
    if ((ZERO_REG != 0) && (bus.raddr1 == '0)) begin
      bus.rdata1 = '0;
    end
  end

  // Read port 2: same priority as port 1.
  always_comb begin
    bus.rdata2 = mem[bus.raddr2];
    if ((BYPASS != 0) && bus.we && (bus.raddr2 == bus.waddr)) begin
      bus.rdata2 = bus.wdata;
    end
    if ((ZERO_REG != 0) && (bus.raddr2 == '0)) begin
      bus.rdata2 = '0;
    end
  end

  // Debug peek shows stored contents only.
  always_comb begin
    bus.dbg_data = mem[bus.dbg_addr];
    if ((ZERO_REG != 0) && (bus.dbg_addr == '0)) begin
      bus.dbg_data = '0;
    end
  end

  // Dump FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Dump FSM next state and beat-load control; abort always wins.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    load_idx   = '0;
    case (state)
      IDLE: begin
        if (bus.dump_start && !bus.dump_abort) begin
          state_next = SEND;
          load       = 1'b1;
        end
      end
      SEND: begin
        if (bus.dump_abort) begin
          state_next = IDLE;
        end else if (bus.dump_ready) begin
          if (dump_addr_q == LAST) begin
            state_next = DONE;
          end else begin
            load     = 1'b1;
            load_idx = dump_addr_q + ADDR_W'(1);
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Beat register: sampled from the pre-write array at the advancing edge,
  // then frozen while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dump_addr_q <= '0;
      dump_data_q <= '0;
    end else if (load) begin
      dump_addr_q <= load_idx;
      if ((ZERO_REG != 0) && (load_idx == '0)) begin
        dump_data_q <= '0;
      end else begin
        dump_data_q <= mem[load_idx];
      end
    end
  end

  // Stream status decodes straight from the state register.
  assign bus.dump_busy  = (state != IDLE);
  assign bus.dump_valid = (state == SEND);
  assign bus.dump_done  = (state == DONE);
  assign bus.dump_addr  = dump_addr_q;
  assign bus.dump_data  = dump_data_q;

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: two instances (ZERO_REG=1/BYPASS=1 and ZERO_REG=0/BYPASS=0)
// driven with identical stimulus; expectations come from an array model and are
// queued for a negedge monitor.
module tb_regfile_dump;

  typedef struct packed {
    logic [31:0] r1;
    logic [31:0] r2;
    logic [31:0] dbg;
  } rd_t;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } beat_t;

  logic clk;
  logic rst;

  regfile_dump_if #(.DATA_W(32), .ADDR_W(5)) ia ();
  regfile_dump_if #(.DATA_W(32), .ADDR_W(5)) ib ();

  regfile_dump #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ia.slave)
  );

  regfile_dump #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ib.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Stimulus for the current cycle.
  logic        s_we;
  logic [4:0]  s_waddr;
  logic [31:0] s_wdata;
  logic [4:0]  s_r1;
  logic [4:0]  s_r2;
  logic [4:0]  s_dbg;
  logic        s_start;
  logic        s_abort;
  logic        s_ready;

  // Reference model: d=0 is the zero-reg/bypass instance, d=1 the plain one.
  logic [31:0] m [2][32];
  rd_t         rq [2][$];
  beat_t       bq [2][$];
  int          phase;   // 0 idle, 1 streaming, 2 done pulse
  int          pos;
  logic        exp_busy;
  logic        exp_done;

  int   vecs;
  int   errs;
  logic run;
  logic in_rst;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %h expected %h at %0t", name, d, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    vecs++;
    errs++;
    $display("FAIL %s: dump did not finish within its cycle budget at %0t", name, $time);
  endtask

  function automatic logic [31:0] exp_rd(input int d, input logic [4:0] a);
    if (d == 0 && a == 5'd0) return 32'd0;
    if (d == 0 && s_we && a == s_waddr) return s_wdata;
    return m[d][a];
  endfunction

  function automatic logic [31:0] exp_dbg(input int d, input logic [4:0] a);
    if (d == 0 && a == 5'd0) return 32'd0;
    return m[d][a];
  endfunction

  task automatic push_beats(input int p);
    beat_t b;
    for (int d = 0; d < 2; d++) begin
      b.addr = 5'(p);
      b.data = (d == 0 && p == 0) ? 32'd0 : m[d][p];
      bq[d].push_back(b);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 32; i++) m[d][i] = 32'd0;
      bq[d].delete();
      rq[d].delete();
    end
    phase    = 0;
    pos      = 0;
    exp_busy = 1'b0;
    exp_done = 1'b0;
  endtask

  // Apply one clock edge to the model using this cycle's stimulus.
  task automatic model_edge();
    if (phase == 2) begin
      phase = 0;
    end else if (phase == 1) begin
      if (s_abort) begin
        phase = 0;
        bq[0].delete();
        bq[1].delete();
      end else if (s_ready) begin
        if (pos == 31) begin
          phase = 2;
        end else begin
          pos++;
          push_beats(pos);
        end
      end
    end else if (s_start && !s_abort) begin
      phase = 1;
      pos   = 0;
      push_beats(0);
    end
    exp_busy = (phase != 0);
    exp_done = (phase == 2);
    for (int d = 0; d < 2; d++) begin
      if (s_we && !(d == 0 && s_waddr == 5'd0)) m[d][s_waddr] = s_wdata;
    end
  endtask

  task automatic drive();
    ia.we = s_we;  ia.waddr = s_waddr;  ia.wdata = s_wdata;
    ia.raddr1 = s_r1;  ia.raddr2 = s_r2;  ia.dbg_addr = s_dbg;
    ia.dump_start = s_start;  ia.dump_abort = s_abort;  ia.dump_ready = s_ready;
    ib.we = s_we;  ib.waddr = s_waddr;  ib.wdata = s_wdata;
    ib.raddr1 = s_r1;  ib.raddr2 = s_r2;  ib.dbg_addr = s_dbg;
    ib.dump_start = s_start;  ib.dump_abort = s_abort;  ib.dump_ready = s_ready;
  endtask

  // One clock: drive, queue read expectations, advance the model after the edge.
  task automatic tick();
    rd_t e;
    drive();
    for (int d = 0; d < 2; d++) begin
      e.r1  = exp_rd(d, s_r1);
      e.r2  = exp_rd(d, s_r2);
      e.dbg = exp_dbg(d, s_dbg);
      rq[d].push_back(e);
    end
    @(posedge clk);
    #1;
    model_edge();
  endtask

  task automatic idle();
    s_we = 1'b0;  s_waddr = 5'd0;  s_wdata = 32'd0;
    s_start = 1'b0;  s_abort = 1'b0;  s_ready = 1'b1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_busy",  0, 32'(ia.dump_busy),  32'd0);
    chk("rst_valid", 0, 32'(ia.dump_valid), 32'd0);
    chk("rst_done",  0, 32'(ia.dump_done),  32'd0);
    chk("rst_addr",  0, 32'(ia.dump_addr),  32'd0);
    chk("rst_data",  0, ia.dump_data,       32'd0);
    chk("rst_busy",  1, 32'(ib.dump_busy),  32'd0);
    chk("rst_valid", 1, 32'(ib.dump_valid), 32'd0);
    chk("rst_done",  1, 32'(ib.dump_done),  32'd0);
    chk("rst_addr",  1, 32'(ib.dump_addr),  32'd0);
    chk("rst_data",  1, ib.dump_data,       32'd0);
  endtask

  task automatic mon(input int d, input logic valid, input logic ready, input logic [4:0] addr,
                     input logic [31:0] data, input logic done, input logic busy,
                     input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] dbg);
    rd_t   e;
    beat_t b;
    if (rq[d].size() > 0) begin
      e = rq[d].pop_front();
      chk("rdata1",   d, r1,  e.r1);
      chk("rdata2",   d, r2,  e.r2);
      chk("dbg_data", d, dbg, e.dbg);
    end
    chk("dump_valid", d, 32'(valid), 32'(bq[d].size() > 0));
    if (valid && bq[d].size() > 0) begin
      b = bq[d][0];
      chk("dump_addr", d, 32'(addr), 32'(b.addr));
      chk("dump_data", d, data, b.data);
      if (ready) void'(bq[d].pop_front());
    end
    chk("dump_done", d, 32'(done), 32'(exp_done));
    chk("dump_busy", d, 32'(busy), 32'(exp_busy));
  endtask

  // Monitor: compares DUT outputs mid-cycle against queued expectations.
  always @(negedge clk) begin
    if (run && !in_rst) begin
      mon(0, ia.dump_valid, ia.dump_ready, ia.dump_addr, ia.dump_data, ia.dump_done,
          ia.dump_busy, ia.rdata1, ia.rdata2, ia.dbg_data);
      mon(1, ib.dump_valid, ib.dump_ready, ib.dump_addr, ib.dump_data, ib.dump_done,
          ib.dump_busy, ib.rdata1, ib.rdata2, ib.dbg_data);
    end
  end

  task automatic drain(input string name, input int budget);
    for (int k = 0; k < budget && phase != 0; k++) begin
      idle();
      tick();
    end
    if (phase != 0) timeout_fail(name);
  endtask

  initial begin
    int stall;
    logic aborted;
    vecs = 0;
    errs = 0;
    run = 1'b0;
    in_rst = 1'b1;
    rst = 1'b0;
    idle();
    s_r1 = 5'd5;  s_r2 = 5'd0;  s_dbg = 5'd5;
    drive();
    model_reset();

    #1 rst = 1'b1;
    #2;
    chk_reset_outputs();
    chk("rst_rdata1", 0, ia.rdata1, 32'd0);
    chk("rst_rdata1", 1, ib.rdata1, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_rst = 1'b0;
    run = 1'b1;

    // Basic write then read.
    idle(); s_we = 1'b1; s_waddr = 5'd5; s_wdata = 32'hDEADBEEF; tick();
    idle(); s_r1 = 5'd5; s_r2 = 5'd0; s_dbg = 5'd5; tick();

    // Register 0 write.
    idle(); s_we = 1'b1; s_waddr = 5'd0; s_wdata = 32'h0000_1234; tick();
    idle(); s_r1 = 5'd0; s_r2 = 5'd5; s_dbg = 5'd0; tick();

    // Same-cycle write/read of r7.
    idle(); s_we = 1'b1; s_waddr = 5'd7; s_wdata = 32'hA5A5A5A5;
    s_r1 = 5'd7; s_r2 = 5'd7; s_dbg = 5'd7; tick();
    idle(); tick();

    // Load reg[i] = i*0x11, then a full-speed dump with a stray start mid-way.
    for (int i = 0; i < 32; i++) begin
      idle(); s_we = 1'b1; s_waddr = 5'(i); s_wdata = 32'(i * 32'h11);
      s_r1 = 5'(i); s_dbg = 5'(i); tick();
    end
    idle(); s_start = 1'b1; tick();
    for (int k = 0; k < 40 && phase != 0; k++) begin
      idle(); s_start = (k == 15); s_r1 = 5'(k); s_dbg = 5'(k); tick();
    end
    if (phase != 0) timeout_fail("full_dump");
    idle(); tick();
    idle(); tick();

    // Stall on beat 3 while overwriting r3.
    idle(); s_start = 1'b1; tick();
    stall = 0;
    for (int k = 0; k < 60 && phase != 0; k++) begin
      idle();
      if (phase == 1 && pos == 3 && stall < 4) begin
        s_ready = 1'b0; s_we = 1'b1; s_waddr = 5'd3; s_wdata = 32'h0000_FFFF;
        stall++;
      end
      tick();
    end
    if (phase != 0) timeout_fail("stall_dump");
    idle(); tick();

    // Abort at beat 10.
    idle(); s_start = 1'b1; tick();
    aborted = 1'b0;
    for (int k = 0; k < 60 && phase != 0; k++) begin
      idle();
      if (phase == 1 && pos == 10 && !aborted) begin
        s_abort = 1'b1;
        aborted = 1'b1;
      end
      tick();
    end
    if (phase != 0) timeout_fail("abort_dump");
    for (int k = 0; k < 3; k++) begin idle(); tick(); end

    // Randomised traffic with dumps, stalls, aborts and start/abort collisions.
    for (int k = 0; k < 1500; k++) begin
      s_we    = 1'($urandom_range(0, 1));
      s_waddr = 5'($urandom_range(0, 31));
      s_wdata = $urandom;
      s_r1    = ($urandom_range(0, 3) == 0) ? s_waddr : 5'($urandom_range(0, 31));
      s_r2    = ($urandom_range(0, 3) == 0) ? s_waddr : 5'($urandom_range(0, 31));
      s_dbg   = ($urandom_range(0, 3) == 0) ? s_waddr : 5'($urandom_range(0, 31));
      s_ready = ($urandom_range(0, 3) != 0);
      s_start = ($urandom_range(0, 19) == 0);
      s_abort = ($urandom_range(0, 59) == 0);
      tick();
    end
    drain("random_drain", 200);

    // Reset in the middle of a dump.
    idle(); s_start = 1'b1; tick();
    for (int k = 0; k < 5; k++) begin idle(); tick(); end
    in_rst = 1'b1;
    rst = 1'b1;
    #1;
    chk_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      idle(); s_r1 = 5'(i); s_r2 = 5'(31 - i); s_dbg = 5'(i); tick();
    end
    for (int k = 0; k < 3; k++) begin idle(); tick(); end

    run = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
